// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_e     - controller states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W - bits per BCD digit
//   ADD3_THRESH - digit value at or above which double-dabble adds 3
//   bcd_add3    - per-digit pre-shift correction
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // A digit >= 5 would become >= 10 after the shift; adding 3 first makes
    // the shift carry into the next digit instead.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_add3(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// ---------------------------------------------------------------------------
// bcd_dabble_step
// One combinational double-dabble iteration over the work register
// {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]}: add 3 to every digit >= 5, then shift
// the whole register left by one.
// Ports:
//   i_work      - current work register
//   o_work      - work register after the iteration
//   o_carry_out - bit shifted out of the top digit (decimal overflow)
// ---------------------------------------------------------------------------
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] i_work,
    output logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] o_work,
    output logic                                o_carry_out
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;

    logic [WORK_W-1:0] w_adj;

    always_comb begin
        w_adj = i_work;
        for (int k = 0; k < DIGITS; k++) begin
            w_adj[BIN_W + BCD_DIGIT_W*k +: BCD_DIGIT_W] =
                bcd_add3(i_work[BIN_W + BCD_DIGIT_W*k +: BCD_DIGIT_W]);
        end
    end

    assign o_carry_out = w_adj[WORK_W-1];
    assign o_work      = {w_adj[WORK_W-2:0], 1'b0};

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Multi-cycle binary-to-BCD converter, one double-dabble iteration per clock.
// Flags decimal overflow and produces a leading-zero blanking mask.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake (ready only while idle)
//   in_bin              - unsigned binary value
//   out_valid/out_ready - output handshake
//   out_bcd             - packed BCD, digit 0 in bits [3:0]
//   out_blank           - 1 = digit is a leading zero (never digit 0)
//   out_ovf             - input >= 10^DIGITS; out_bcd holds value mod 10^DIGITS
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]             out_blank,
    output logic                          out_ovf
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    state_e              r_state;
    logic [WORK_W-1:0]   r_work;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [BCD_W-1:0]    r_bcd;
    logic [DIGITS-1:0]   r_blank;
    logic                r_ovf_out;

    logic [WORK_W-1:0]   w_work_next;
    logic                w_carry;
    logic [BCD_W-1:0]    w_bcd_next;
    logic                w_ovf_next;
    logic [DIGITS-1:0]   w_blank_next;
    logic                w_any_nz;
    logic                w_last;

    bcd_dabble_step #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .i_work      (r_work),
        .o_work      (w_work_next),
        .o_carry_out (w_carry)
    );

    assign w_bcd_next = w_work_next[WORK_W-1 -: BCD_W];
    assign w_ovf_next = r_ovf | w_carry;
    assign w_last     = (r_cnt == CNT_W'(1));

    // Downward prefix-OR: a digit is blank only if it and every digit above it
    // are zero. Digit 0 always shows; an overflowed value shows all digits.
    always_comb begin
        w_any_nz     = 1'b0;
        w_blank_next = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_any_nz        = w_any_nz | (|w_bcd_next[BCD_DIGIT_W*k +: BCD_DIGIT_W]);
            w_blank_next[k] = ~w_any_nz;
        end
        if (w_ovf_next) begin
            w_blank_next = '0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
            r_blank   <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cnt   <= CNT_W'(BIN_W);
                        r_ovf   <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_ovf <= w_ovf_next;
                    if (w_last) begin
                        r_bcd     <= w_bcd_next;
                        r_blank   <= w_blank_next;
                        r_ovf_out <= w_ovf_next;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Work register: data only, always (re)loaded on acceptance
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && in_valid) begin
            r_work <= {{BCD_W{1'b0}}, in_bin};
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_work_next;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_bcd   = r_bcd;
    assign out_blank = r_blank;
    assign out_ovf   = r_ovf_out;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq: default 20-bit/6-digit instance plus two
// 8-bit instances (3 and 2 digits) driven with common inputs.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_bin = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_bcd;
    logic [5:0]  out_blank;
    logic        out_ovf;

    logic        in_valid8 = 1'b0;
    logic [7:0]  in_bin8 = '0;
    logic        out_ready8 = 1'b0;
    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [11:0] out_bcd_a;
    logic [2:0]  out_blank_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [7:0]  out_bcd_b;
    logic [1:0]  out_blank_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_blank(out_blank), .out_ovf(out_ovf)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready_a), .in_bin(in_bin8),
        .out_valid(out_valid_a), .out_ready(out_ready8),
        .out_bcd(out_bcd_a), .out_blank(out_blank_a), .out_ovf(out_ovf_a)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready_b), .in_bin(in_bin8),
        .out_valid(out_valid_b), .out_ready(out_ready8),
        .out_bcd(out_bcd_b), .out_blank(out_blank_b), .out_ovf(out_ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present v, complete the input handshake on the next edge, then drop in_valid.
    task automatic accept20(input logic [19:0] v);
        in_bin   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid; -1 if the bound expires.
    task automatic wait_valid20(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic drain20(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_valid_after_F"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_after_F"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run20(input string tag, input logic [19:0] v, input logic [23:0] e_bcd,
                         input logic [5:0] e_blank, input logic e_ovf);
        int cyc;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        accept20(v);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid20(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'd20);
        chk({tag, "_bcd"},   32'(out_bcd),   32'(e_bcd));
        chk({tag, "_blank"}, 32'(out_blank), 32'(e_blank));
        chk({tag, "_ovf"},   32'(out_ovf),   32'(e_ovf));
        drain20(tag);
    endtask

    task automatic run8(input string tag, input logic [7:0] v,
                        input logic [11:0] ea_bcd, input logic [2:0] ea_blank, input logic ea_ovf,
                        input logic [7:0]  eb_bcd, input logic [1:0] eb_blank, input logic eb_ovf);
        int cyc;
        in_bin8   = v;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_a) begin
                cyc = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd8);
        chk({tag, "_d3_bcd"},   32'(out_bcd_a),   32'(ea_bcd));
        chk({tag, "_d3_blank"}, 32'(out_blank_a), 32'(ea_blank));
        chk({tag, "_d3_ovf"},   32'(out_ovf_a),   32'(ea_ovf));
        chk({tag, "_d2_valid"}, 32'(out_valid_b), 32'd1);
        chk({tag, "_d2_bcd"},   32'(out_bcd_b),   32'(eb_bcd));
        chk({tag, "_d2_blank"}, 32'(out_blank_b), 32'(eb_blank));
        chk({tag, "_d2_ovf"},   32'(out_ovf_b),   32'(eb_ovf));
        out_ready8 = 1'b1;
        @(posedge clk);
        #1 out_ready8 = 1'b0;
        chk({tag, "_d3_ready_after_F"}, 32'(in_ready_a), 32'd1);
        chk({tag, "_d2_ready_after_F"}, 32'(in_ready_b), 32'd1);
    endtask

    initial begin
        int cyc;
        int seen;

        // Reset
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bcd",   32'(out_bcd),   32'd0);
        chk("rst_out_blank", 32'(out_blank), 32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Main conversions
        run20("v999999", 20'd999999,  24'h999999, 6'b000000, 1'b0);
        run20("v1048575", 20'd1048575, 24'h048575, 6'b000000, 1'b1);
        run20("v0",  20'd0,  24'h000000, 6'b111110, 1'b0);
        run20("v42", 20'd42, 24'h000042, 6'b111100, 1'b0);
        run20("v1000000", 20'd1000000, 24'h000000, 6'b000000, 1'b1);

        // Output back-pressure with a pending input that must not be taken
        accept20(20'd42);
        wait_valid20(cyc);
        chk("stall_latency", 32'(cyc), 32'd20);
        in_bin   = 20'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_bcd", 32'(out_bcd), 32'h000042);
            chk("stall_blank", 32'(out_blank), 32'b111100);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("stall_idle_valid", 32'(out_valid), 32'd0);
        chk("stall_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("stall_7_taken", 32'(in_ready), 32'd0);
        wait_valid20(cyc);
        chk("v7_latency", 32'(cyc), 32'd20);
        chk("v7_bcd",   32'(out_bcd),   32'h000007);
        chk("v7_blank", 32'(out_blank), 32'b111110);
        drain20("v7");

        // Reset in the middle of SHIFT
        accept20(20'd555);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("abort_valid_in_rst", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        run20("v123", 20'd123, 24'h000123, 6'b111000, 1'b0);

        // Narrow instances
        run8("n255", 8'd255, 12'h255, 3'b000, 1'b0, 8'h55, 2'b00, 1'b1);
        run8("n5",   8'd5,   12'h005, 3'b110, 1'b0, 8'h05, 2'b10, 1'b0);
        run8("n100", 8'd100, 12'h100, 3'b000, 1'b0, 8'h00, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
